// File: rtl/ahb_pkg.sv
// ahb_pkg
// Shared AHB-Lite encodings and helpers for the bus arbiter.
//   htrans_e       : HTRANS transfer-type encodings (IDLE/BUSY/NONSEQ/SEQ)
//   HBURST_*       : HBURST encodings
//   burst_beats()  : beat count of a fixed-length burst (1 for SINGLE/INCR)
//   onehot_to_idx(): index of the set bit of a one-hot vector (up to 16 bits)
package ahb_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'd0,
    HTRANS_BUSY   = 2'd1,
    HTRANS_NONSEQ = 2'd2,
    HTRANS_SEQ    = 2'd3
  } htrans_e;

  localparam logic [2:0] HBURST_SINGLE = 3'd0;
  localparam logic [2:0] HBURST_INCR   = 3'd1;
  localparam logic [2:0] HBURST_WRAP4  = 3'd2;
  localparam logic [2:0] HBURST_INCR4  = 3'd3;
  localparam logic [2:0] HBURST_WRAP8  = 3'd4;
  localparam logic [2:0] HBURST_INCR8  = 3'd5;
  localparam logic [2:0] HBURST_WRAP16 = 3'd6;
  localparam logic [2:0] HBURST_INCR16 = 3'd7;

  // Undefined-length INCR counts as a single beat so it re-arbitrates every beat.
  function automatic logic [4:0] burst_beats(input logic [2:0] hburst);
    logic [4:0] beats;
    case (hburst)
      HBURST_WRAP4,  HBURST_INCR4:  beats = 5'd4;
      HBURST_WRAP8,  HBURST_INCR8:  beats = 5'd8;
      HBURST_WRAP16, HBURST_INCR16: beats = 5'd16;
      default:                      beats = 5'd1;
    endcase
    return beats;
  endfunction

  // OR-reduction of set-bit positions; exact for one-hot input.
  function automatic logic [3:0] onehot_to_idx(input logic [15:0] onehot);
    logic [3:0] idx;
    idx = '0;
    for (int i = 0; i < 16; i++) begin
      if (onehot[i]) idx = idx | 4'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/ahb_rr_picker.sv
// ahb_rr_picker
// Combinational rotating-priority picker.
//   req   in  N   request vector
//   base  in  IW  index holding highest priority when mode=1
//   mode  in  1   0 = fixed priority (index 0 highest), 1 = rotate from base
//   grant out N   one-hot winner (zero when no request)
//   valid out 1   at least one request present
module ahb_rr_picker #(
  parameter int N  = 2,
  parameter int IW = 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] base,
  input  logic          mode,
  output logic [N-1:0]  grant,
  output logic          valid
);

  localparam logic [N-1:0] ONE = N'(1);

  logic [IW-1:0]  start;
  logic [2*N-1:0] req_dbl;
  logic [N-1:0]   req_rot;
  logic [N-1:0]   grant_rot;
  logic [2*N-1:0] grant_dbl;

  // Rotate requests so that 'start' lands on bit 0, isolate the lowest set
  // bit, then rotate the winner back into its original position.
  assign start     = mode ? base : '0;
  assign req_dbl   = {req, req} >> start;
  assign req_rot   = req_dbl[N-1:0];
  assign grant_rot = req_rot & (~req_rot + ONE);
  assign grant_dbl = {grant_rot, grant_rot} << start;
  assign grant     = grant_dbl[2*N-1:N];
  assign valid     = |req;

endmodule

// File: rtl/ahb_arbiter_n.sv
// ahb_arbiter_n
// N-master AHB-Lite bus arbiter with fixed-priority or round-robin selection,
// fixed-length burst hold, locked-transfer hold and a default master.
//   hclk      in   1   bus clock
//   hresetn   in   1   asynchronous active-low reset
//   hbusreq   in   N   per-master bus request
//   hlock     in   N   per-master locked-access request
//   htrans    in   2   HTRANS of the current address-phase owner
//   hburst    in   3   HBURST of the current address-phase owner
//   hready    in   1   HREADY; all state advances only when high
//   hgrant    out  N   one-hot grant (registered)
//   hmaster   out  MW  address-phase owner index (registered)
//   hmastlock out  1   current address-phase transfer is locked (registered)
module ahb_arbiter_n
  import ahb_pkg::*;
#(
  parameter int NUM_MASTERS    = 2,
  parameter int DEFAULT_MASTER = 0,
  parameter int ARB_MODE       = 0,
  localparam int MW = (NUM_MASTERS > 2) ? $clog2(NUM_MASTERS) : 1
) (
  input  logic                   hclk,
  input  logic                   hresetn,
  input  logic [NUM_MASTERS-1:0] hbusreq,
  input  logic [NUM_MASTERS-1:0] hlock,
  input  logic [1:0]             htrans,
  input  logic [2:0]             hburst,
  input  logic                   hready,
  output logic [NUM_MASTERS-1:0] hgrant,
  output logic [MW-1:0]          hmaster,
  output logic                   hmastlock
);

  localparam logic [NUM_MASTERS-1:0] DEFAULT_GRANT = NUM_MASTERS'(1) << DEFAULT_MASTER;
  localparam logic [MW-1:0]          DEFAULT_IDX   = MW'(DEFAULT_MASTER);
  localparam logic [MW-1:0]          LAST_IDX      = MW'(NUM_MASTERS - 1);
  localparam logic [MW-1:0]          ONE_IDX       = MW'(1);
  localparam logic                   RR_MODE       = (ARB_MODE != 0);

  logic [NUM_MASTERS-1:0] hgrant_reg;
  logic [MW-1:0]          hmaster_reg;
  logic                   hmastlock_reg;
  logic [3:0]             beat_cnt_reg;
  logic [3:0]             beat_cnt_next;
  logic [MW-1:0]          rr_last_reg;

  logic [4:0]             beats_m1;
  logic [3:0]             owner_wide;
  logic [MW-1:0]          owner_idx;
  logic                   owner_locked;
  logic                   arb_ok;
  logic [MW-1:0]          rr_base;
  logic [NUM_MASTERS-1:0] pick_grant;
  logic                   pick_valid;
  logic [NUM_MASTERS-1:0] win_grant;
  logic [3:0]             win_wide;
  logic [MW-1:0]          win_idx;

  assign beats_m1 = burst_beats(hburst) - 5'd1;

  // Remaining beats after this one. A NONSEQ always reloads, so a new burst
  // starting on the edge where the old one ends is held correctly.
  always_comb begin
    beat_cnt_next = beat_cnt_reg;
    case (htrans_e'(htrans))
      HTRANS_IDLE:   beat_cnt_next = 4'd0;
      HTRANS_NONSEQ: beat_cnt_next = beats_m1[3:0];
      HTRANS_SEQ:    if (beat_cnt_reg != 4'd0) beat_cnt_next = beat_cnt_reg - 4'd1;
      default:       beat_cnt_next = beat_cnt_reg;
    endcase
  end

  assign owner_wide   = onehot_to_idx(16'(hgrant_reg));
  assign owner_idx    = owner_wide[MW-1:0];
  assign owner_locked = hlock[owner_idx] && hbusreq[owner_idx];

  // Re-arbitrate while the last beat of a burst is in its address phase so
  // the next owner is granted in time to follow it without a bubble.
  assign arb_ok = (beat_cnt_next <= 4'd1) && !owner_locked;

  assign rr_base = (rr_last_reg == LAST_IDX) ? '0 : rr_last_reg + ONE_IDX;

  ahb_rr_picker #(
    .N  (NUM_MASTERS),
    .IW (MW)
  ) u_picker (
    .req   (hbusreq),
    .base  (rr_base),
    .mode  (RR_MODE),
    .grant (pick_grant),
    .valid (pick_valid)
  );

  assign win_grant = pick_valid ? pick_grant : DEFAULT_GRANT;
  assign win_wide  = onehot_to_idx(16'(win_grant));
  assign win_idx   = win_wide[MW-1:0];

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      hgrant_reg    <= DEFAULT_GRANT;
      hmaster_reg   <= DEFAULT_IDX;
      hmastlock_reg <= 1'b0;
      beat_cnt_reg  <= 4'd0;
      rr_last_reg   <= DEFAULT_IDX;
    end else if (hready) begin
      hmaster_reg   <= owner_idx;
      hmastlock_reg <= hlock[owner_idx];
      beat_cnt_reg  <= beat_cnt_next;
      if (arb_ok) begin
        hgrant_reg <= win_grant;
        if (win_grant != hgrant_reg) rr_last_reg <= win_idx;
      end
    end
  end

  assign hgrant    = hgrant_reg;
  assign hmaster   = hmaster_reg;
  assign hmastlock = hmastlock_reg;

endmodule

// File: tb/tb_ahb_arbiter_n.sv
// tb_ahb_arbiter_n
// Directed bench for ahb_arbiter_n: a fixed-priority and a round-robin
// instance (4 masters, default master 2) share the same request inputs.
module tb_ahb_arbiter_n;
  import ahb_pkg::*;

  logic       hclk = 1'b0;
  logic       hresetn = 1'b1;
  logic [3:0] hbusreq = '0;
  logic [3:0] hlock = '0;
  logic [1:0] htrans = 2'd0;
  logic [2:0] hburst = 3'd0;
  logic       hready = 1'b1;

  logic [3:0] g_fix, g_rr;
  logic [1:0] m_fix, m_rr;
  logic       l_fix, l_rr;

  int total = 0;
  int bad   = 0;

  always #5 hclk = ~hclk;

  ahb_arbiter_n #(.NUM_MASTERS(4), .DEFAULT_MASTER(2), .ARB_MODE(0)) u_fix (
    .hclk(hclk), .hresetn(hresetn), .hbusreq(hbusreq), .hlock(hlock),
    .htrans(htrans), .hburst(hburst), .hready(hready),
    .hgrant(g_fix), .hmaster(m_fix), .hmastlock(l_fix)
  );

  ahb_arbiter_n #(.NUM_MASTERS(4), .DEFAULT_MASTER(2), .ARB_MODE(1)) u_rr (
    .hclk(hclk), .hresetn(hresetn), .hbusreq(hbusreq), .hlock(hlock),
    .htrans(htrans), .hburst(hburst), .hready(hready),
    .hgrant(g_rr), .hmaster(m_rr), .hmastlock(l_rr)
  );

  task automatic tick();
    @(posedge hclk);
    #1;
    $display("t=%0t req=%b lock=%b trans=%0d burst=%0d rdy=%b | fix g=%b m=%0d l=%b | rr g=%b m=%0d l=%b",
             $time, hbusreq, hlock, htrans, hburst, hready, g_fix, m_fix, l_fix, g_rr, m_rr, l_rr);
  endtask

  task automatic do_reset();
    hresetn = 1'b0;
    hbusreq = '0;
    hlock   = '0;
    htrans  = HTRANS_IDLE;
    hburst  = HBURST_SINGLE;
    hready  = 1'b1;
    @(posedge hclk);
    #1;
    hresetn = 1'b1;
  endtask

  task automatic test_reset();
    #1;
    hresetn = 1'b0;
    #1;
    // Asynchronous: values must appear before any clock edge.
    total++; if (g_fix !== 4'b0100) begin bad++; $display("FAIL reset_async_grant_fix got=%b want=%b", g_fix, 4'b0100); end
    total++; if (m_fix !== 2'd2) begin bad++; $display("FAIL reset_async_hmaster_fix got=%0d want=%0d", m_fix, 2); end
    total++; if (l_fix !== 1'b0) begin bad++; $display("FAIL reset_async_lock_fix got=%b want=%b", l_fix, 1'b0); end
    total++; if (g_rr !== 4'b0100) begin bad++; $display("FAIL reset_async_grant_rr got=%b want=%b", g_rr, 4'b0100); end
    do_reset();
    for (int k = 0; k < 10; k++) begin
      tick();
      total++; if (g_fix !== 4'b0100 || m_fix !== 2'd2 || l_fix !== 1'b0) begin
        bad++; $display("FAIL idle_default_fix cyc=%0d got g=%b m=%0d l=%b want g=0100 m=2 l=0", k, g_fix, m_fix, l_fix);
      end
      total++; if (g_rr !== 4'b0100 || m_rr !== 2'd2) begin
        bad++; $display("FAIL idle_default_rr cyc=%0d got g=%b m=%0d want g=0100 m=2", k, g_rr, m_rr);
      end
    end
  endtask

  task automatic test_fixed_priority();
    do_reset();
    hbusreq = 4'b1010;
    tick();
    total++; if (g_fix !== 4'b0010) begin bad++; $display("FAIL fixed_grant got=%b want=%b", g_fix, 4'b0010); end
    total++; if (m_fix !== 2'd2) begin bad++; $display("FAIL fixed_hmaster_lag got=%0d want=%0d", m_fix, 2); end
    // Round robin searches from rr_last+1 = 3.
    total++; if (g_rr !== 4'b1000) begin bad++; $display("FAIL rr_first_from_base got=%b want=%b", g_rr, 4'b1000); end
    tick();
    total++; if (m_fix !== 2'd1) begin bad++; $display("FAIL fixed_hmaster got=%0d want=%0d", m_fix, 1); end
    total++; if (g_rr !== 4'b0010) begin bad++; $display("FAIL rr_wrap_next got=%b want=%b", g_rr, 4'b0010); end
    total++; if (m_rr !== 2'd3) begin bad++; $display("FAIL rr_hmaster got=%0d want=%0d", m_rr, 3); end
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_g;
    logic [1:0] exp_m;
    do_reset();
    hbusreq = 4'b1111;
    htrans  = HTRANS_NONSEQ;
    hburst  = HBURST_SINGLE;
    for (int k = 1; k <= 8; k++) begin
      tick();
      exp_g = 4'b0001 << ((2 + k) % 4);
      exp_m = 2'((1 + k) % 4);
      total++; if (g_rr !== exp_g) begin bad++; $display("FAIL rr_order step=%0d got=%b want=%b", k, g_rr, exp_g); end
      total++; if (m_rr !== exp_m) begin bad++; $display("FAIL rr_hmaster step=%0d got=%0d want=%0d", k, m_rr, exp_m); end
      total++; if (g_fix !== 4'b0001) begin bad++; $display("FAIL fixed_all_req step=%0d got=%b want=%b", k, g_fix, 4'b0001); end
    end
  endtask

  task automatic test_burst_hold();
    do_reset();
    hbusreq = 4'b0001;
    tick();
    tick();
    total++; if (g_fix !== 4'b0001 || m_fix !== 2'd0) begin
      bad++; $display("FAIL burst_setup got g=%b m=%0d want g=0001 m=0", g_fix, m_fix);
    end
    // Beat 1: NONSEQ INCR4, master 1 starts requesting.
    htrans = HTRANS_NONSEQ; hburst = HBURST_INCR4; hbusreq = 4'b0011;
    tick();
    total++; if (g_fix !== 4'b0001) begin bad++; $display("FAIL burst_hold_beat1 got=%b want=%b", g_fix, 4'b0001); end
    // Beat 2: owner drops its request, grant must still hold.
    htrans = HTRANS_SEQ; hbusreq = 4'b0010;
    tick();
    total++; if (g_fix !== 4'b0001) begin bad++; $display("FAIL burst_hold_beat2 got=%b want=%b", g_fix, 4'b0001); end
    // Two wait states on beat 3.
    hready = 1'b0;
    tick();
    tick();
    total++; if (g_fix !== 4'b0001 || m_fix !== 2'd0) begin
      bad++; $display("FAIL burst_wait_hold got g=%b m=%0d want g=0001 m=0", g_fix, m_fix);
    end
    hready = 1'b1;
    tick();
    total++; if (g_fix !== 4'b0010) begin bad++; $display("FAIL burst_regrant_beat3 got=%b want=%b", g_fix, 4'b0010); end
    total++; if (m_fix !== 2'd0) begin bad++; $display("FAIL burst_hmaster_beat3 got=%0d want=%0d", m_fix, 0); end
    // Beat 4 completes.
    tick();
    total++; if (m_fix !== 2'd1) begin bad++; $display("FAIL burst_hmaster_after got=%0d want=%0d", m_fix, 1); end
    total++; if (g_fix !== 4'b0010) begin bad++; $display("FAIL burst_grant_after got=%b want=%b", g_fix, 4'b0010); end
  endtask

  task automatic test_lock_release();
    do_reset();
    hbusreq = 4'b0010; hlock = 4'b0010;
    tick();
    total++; if (g_fix !== 4'b0010) begin bad++; $display("FAIL lock_grant got=%b want=%b", g_fix, 4'b0010); end
    tick();
    total++; if (m_fix !== 2'd1 || l_fix !== 1'b1) begin
      bad++; $display("FAIL lock_owner got m=%0d l=%b want m=1 l=1", m_fix, l_fix);
    end
    hbusreq = 4'b0011; htrans = HTRANS_NONSEQ; hburst = HBURST_INCR;
    tick();
    total++; if (g_fix !== 4'b0010) begin bad++; $display("FAIL lock_hold_nonseq got=%b want=%b", g_fix, 4'b0010); end
    htrans = HTRANS_SEQ;
    for (int k = 0; k < 3; k++) begin
      tick();
      total++; if (g_fix !== 4'b0010 || l_fix !== 1'b1) begin
        bad++; $display("FAIL lock_hold_seq cyc=%0d got g=%b l=%b want g=0010 l=1", k, g_fix, l_fix);
      end
    end
    hlock = 4'b0000; htrans = HTRANS_IDLE;
    tick();
    total++; if (g_fix !== 4'b0001) begin bad++; $display("FAIL lock_release_grant got=%b want=%b", g_fix, 4'b0001); end
    total++; if (l_fix !== 1'b0) begin bad++; $display("FAIL lock_release_mastlock got=%b want=%b", l_fix, 1'b0); end
    tick();
    total++; if (m_fix !== 2'd0) begin bad++; $display("FAIL lock_release_hmaster got=%0d want=%0d", m_fix, 0); end
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    hbusreq = 4'b1000;
    tick();
    tick();
    total++; if (g_fix !== 4'b1000 || m_fix !== 2'd3) begin
      bad++; $display("FAIL midrst_setup got g=%b m=%0d want g=1000 m=3", g_fix, m_fix);
    end
    htrans = HTRANS_NONSEQ; hburst = HBURST_INCR8;
    tick();
    htrans = HTRANS_SEQ;
    tick();
    hresetn = 1'b0;
    #2;
    total++; if (g_fix !== 4'b0100 || m_fix !== 2'd2 || l_fix !== 1'b0) begin
      bad++; $display("FAIL midrst_async_fix got g=%b m=%0d l=%b want g=0100 m=2 l=0", g_fix, m_fix, l_fix);
    end
    total++; if (g_rr !== 4'b0100 || m_rr !== 2'd2) begin
      bad++; $display("FAIL midrst_async_rr got g=%b m=%0d want g=0100 m=2", g_rr, m_rr);
    end
    hresetn = 1'b1;
    // Stale SEQ after reset: a cleared beat counter lets arbitration happen now.
    hbusreq = 4'b0001;
    tick();
    total++; if (g_fix !== 4'b0001) begin bad++; $display("FAIL midrst_first_arb got=%b want=%b", g_fix, 4'b0001); end
    tick();
    total++; if (m_fix !== 2'd0) begin bad++; $display("FAIL midrst_hmaster got=%0d want=%0d", m_fix, 0); end
  endtask

  initial begin
    test_reset();
    test_fixed_priority();
    test_round_robin();
    test_burst_hold();
    test_lock_release();
    test_reset_mid_burst();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog_timeout got=running want=finished");
    $fatal(1, "watchdog expired");
  end

endmodule
